fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Program-counter register and instruction-fetch stage of the multi-cycle core.
- Holds the PC, requests the instruction word at that PC from instruction memory, and presents the word to decode/control with a valid/ready handshake.
- Exposes the PC as pc_current to the branch resolver and loads the resolver's pc_next when control strobes pc_load.
- Handles redirects while a fetch is in flight (drains the stale response) and flags memory timeouts.

Parameters:
- RESET_PC, 16'h0000: PC value loaded on reset.
- TIMEOUT_CYCLES, 255: cycles a request may stay unanswered before a fault; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- pc_next  in  16  next PC from branch resolver.
- pc_load  in  1  strobe: load pc_next into PC and redirect fetch.
- imem_req  out  1  fetch request, held high until imem_valid.
- imem_addr  out  16  fetch address, stable while imem_req=1.
- imem_valid  in  1  one-cycle pulse; exactly one per request.
- imem_rdata  in  16  instruction word, valid with imem_valid.
- instr  out  16  fetched instruction to decode.
- instr_valid  out  1  instr holds a valid instruction.
- instr_ready  in  1  decode accepts instr.
- pc_current  out  16  PC of the instruction held or being fetched.
- fetch_fault  out  1  sticky memory-timeout flag.

Behaviour:
- States: IDLE, REQ, DRAIN, HOLD, WAIT_PC, FAULT.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, pc=RESET_PC, instr=0.
  - instr_valid=0, imem_req=0, fetch_fault=0, timeout counter=0.
  - Reset overrides every other input, including mid-fetch. A response arriving after reset is ignored because imem_valid is only sampled in REQ/DRAIN.
- pc_current = pc register at all times. imem_addr = address latched when the request started.
- IDLE: goes to REQ on the next cycle. The first imem_req rises one cycle after rst_n goes high.
- REQ (imem_req=1, imem_addr=pc):
  - imem_valid && !pc_load: instr<=imem_rdata, go to HOLD. instr_valid=1 the cycle after the response (latency 1).
  - pc_load && imem_valid: response discarded, pc<=pc_next, stay in REQ. The new address is presented from the next cycle.
  - pc_load && !imem_valid: pc<=pc_next, go to DRAIN.
- DRAIN: imem_req=1 and imem_addr stays the old address until imem_valid, then go to REQ with the new pc. A further pc_load in DRAIN overwrites pc again.
- HOLD (instr_valid=1, instr stable):
  - instr_ready && !pc_load: go to WAIT_PC; instr_valid=0 next cycle.
  - pc_load: wins over instr_ready, and the transfer is void. pc<=pc_next, instr_valid=0, go to REQ.
- WAIT_PC: idle, no request. pc_load: pc<=pc_next, go to REQ. Otherwise stay indefinitely.
- Timeout:
  - Counter clears on entry to REQ/DRAIN and increments each REQ/DRAIN cycle without imem_valid.
  - When it reaches TIMEOUT_CYCLES (nonzero): go to FAULT.
- FAULT: fetch_fault=1, imem_req=0, instr_valid=0, pc frozen. pc_load, imem_valid and instr_ready are ignored. Exits only on reset.
- Arithmetic: PC is 16-bit unsigned. pc_next is taken verbatim, including 16'hFFFF; no increment is done in this block.
- Counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1.

Test Plan:
- Reset then run: RESET_PC=0, memory answers after 2 cycles with 16'hA123 -> imem_req rises cycle 1, imem_addr=0, instr=16'hA123 with instr_valid=1 one cycle after imem_valid; pc_current=0.
- Handshake and stall: hold instr_ready=0 for 5 cycles -> instr/instr_valid stable. Ready=1 -> WAIT_PC. pc_load with pc_next=16'h0005 -> next imem_addr=5.
- Redirect in flight: pc_load (pc_next=16'h0040) while waiting on a fetch of 0x0006 -> stale response 16'hDEAD never appears on instr. The next request uses addr 0x0040, and its data is delivered.
- Simultaneous events: pc_load in the same cycle as imem_valid in REQ -> no instr_valid, new address next cycle. pc_load together with instr_ready in HOLD -> instr_valid drops, fetch goes to pc_next.
- Timeout: TIMEOUT_CYCLES=4, memory never answers -> fetch_fault=1 on the 4th unanswered cycle, imem_req=0. A later pc_load has no effect; rst_n=0 clears the fault.
- Wrap and reset mid-fetch: pc_next=16'hFFFF -> imem_addr=16'hFFFF. rst_n=0 during DRAIN -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: the instruction-memory request channel and the
// decode handshake. master = fetch unit, slave = memory/decode side.
interface fetch_unit_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid;
    logic [15:0] imem_rdata;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;

    modport master (
        output imem_req, imem_addr, instr, instr_valid,
        input  imem_valid, imem_rdata, instr_ready
    );
    modport slave (
        input  imem_req, imem_addr, instr, instr_valid,
        output imem_valid, imem_rdata, instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// PC register and instruction-fetch stage: one outstanding fetch, redirect with
// stale-response drain, and a sticky timeout fault.
module fetch_unit #(
    parameter logic [15:0] RESET_PC       = 16'h0000,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [15:0]   pc_next,
    input  logic          pc_load,
    fetch_unit_if.master  bus,
    output logic [15:0]   pc_current,
    output logic          fetch_fault
);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {IDLE, REQ, DRAIN, HOLD, WAIT_PC, FAULT} state_t;

    state_t        state, state_d;
    logic [15:0]   pc, pc_d;
    logic [15:0]   addr_q;
    logic [15:0]   instr_q, instr_d;
    logic [CW-1:0] cnt, cnt_d, cnt_inc;
    logic          timeout_hit;

    assign cnt_inc     = cnt + 1'b1;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TO_LIMIT);

    // Counter stays zero in every path except an unanswered cycle that keeps
    // the same request alive, so each new request starts counting from zero.
    always_comb begin
        state_d = state;
        pc_d    = pc;
        instr_d = instr_q;
        cnt_d   = '0;
        unique case (state)
            IDLE: state_d = REQ;
            REQ: begin
                if (bus.imem_valid) begin
                    if (pc_load) begin
                        pc_d = pc_next;
                    end else begin
                        instr_d = bus.imem_rdata;
                        state_d = HOLD;
                    end
                end else if (pc_load) begin
                    pc_d    = pc_next;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_inc;
                    if (timeout_hit) state_d = FAULT;
                end
            end
            DRAIN: begin
                if (pc_load) pc_d = pc_next;
                if (bus.imem_valid) begin
                    state_d = REQ;
                end else begin
                    cnt_d = cnt_inc;
                    if (timeout_hit) state_d = FAULT;
                end
            end
            HOLD: begin
                if (pc_load) begin
                    pc_d    = pc_next;
                    state_d = REQ;
                end else if (bus.instr_ready) begin
                    state_d = WAIT_PC;
                end
            end
            WAIT_PC: begin
                if (pc_load) begin
                    pc_d    = pc_next;
                    state_d = REQ;
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            addr_q  <= RESET_PC;
            instr_q <= '0;
            cnt     <= '0;
        end else begin
            state   <= state_d;
            pc      <= pc_d;
            instr_q <= instr_d;
            cnt     <= cnt_d;
            // Remember the in-flight address so DRAIN keeps it after pc moves.
            if (state == REQ) addr_q <= pc;
        end
    end

    assign bus.imem_req    = (state == REQ) || (state == DRAIN);
    assign bus.imem_addr   = (state == DRAIN) ? addr_q : pc;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = (state == HOLD);
    assign pc_current      = pc;
    assign fetch_fault     = (state == FAULT);
endmodule

// File: tb/tb_fetch_unit.sv
// Fetch unit bench: transaction-level model of the fetch rules, compared on
// every cycle, plus directed scenarios pinned with literal expectations.
module tb_fetch_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_load = 1'b0;
  logic [15:0] pc_next = '0;
  logic [15:0] pc_current;
  logic        fetch_fault;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(16'h0000), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .pc_next(pc_next), .pc_load(pc_load),
    .bus(bus.master), .pc_current(pc_current), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  // Model: what the fetch stage owes the outside world, by transaction.
  logic [15:0] m_pc = 16'h0000, m_addr = 16'h0000, m_instr = 16'h0000;
  bit m_started = 0, m_fetching = 0, m_stale = 0, m_have = 0, m_waiting = 0, m_fault = 0;
  int m_quiet = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc = 16'h0000; m_addr = 16'h0000; m_instr = 16'h0000;
      m_started = 0; m_fetching = 0; m_stale = 0; m_have = 0; m_waiting = 0;
      m_fault = 0; m_quiet = 0;
    end else if (m_fault) begin
      // frozen until reset
    end else if (!m_started) begin
      m_started = 1; m_fetching = 1; m_addr = m_pc; m_quiet = 0;
    end else if (m_fetching) begin
      if (bus.imem_valid) begin
        if (pc_load) begin
          m_pc = pc_next; m_addr = pc_next; m_stale = 0; m_quiet = 0;
        end else if (m_stale) begin
          m_stale = 0; m_addr = m_pc; m_quiet = 0;
        end else begin
          m_instr = bus.imem_rdata; m_have = 1; m_fetching = 0;
        end
      end else if (pc_load && !m_stale) begin
        m_pc = pc_next; m_stale = 1; m_quiet = 0;
      end else begin
        if (pc_load) m_pc = pc_next;
        m_quiet++;
        if (TO != 0 && m_quiet == TO) begin m_fault = 1; m_fetching = 0; end
      end
    end else if (m_have) begin
      if (pc_load) begin
        m_pc = pc_next; m_have = 0; m_fetching = 1; m_addr = pc_next; m_quiet = 0;
      end else if (bus.instr_ready) begin
        m_have = 0; m_waiting = 1;
      end
    end else if (m_waiting) begin
      if (pc_load) begin
        m_pc = pc_next; m_waiting = 0; m_fetching = 1; m_addr = pc_next; m_quiet = 0;
      end
    end
  end

  int checks = 0, failures = 0;
  bit chk_en = 0, auto_mem = 0, mbusy = 0;
  int mwait = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp();
    chk("imem_req", 16'(bus.imem_req), 16'(m_fetching));
    if (m_fetching) chk("imem_addr", bus.imem_addr, m_addr);
    chk("instr_valid", 16'(bus.instr_valid), 16'(m_have));
    chk("instr", bus.instr, m_instr);
    chk("pc_current", pc_current, m_pc);
    chk("fetch_fault", 16'(fetch_fault), 16'(m_fault));
  endtask

  // Inputs change 1 time unit after the edge; outputs are checked at negedge.
  task automatic step(input logic r, input logic ld, input logic [15:0] nx,
                      input logic rdy, input logic mv, input logic [15:0] md);
    logic v;
    logic [15:0] d;
    @(posedge clk); #1;
    v = mv; d = md;
    if (auto_mem) begin
      v = 1'b0;
      if (!r) mbusy = 0;
      else if (bus.imem_req) begin
        if (!mbusy) begin mbusy = 1; mwait = $urandom_range(0, 2); end
        if (mwait == 0) begin v = 1'b1; d = 16'($urandom); mbusy = 0; end
        else mwait--;
      end
    end
    rst_n = r; pc_load = ld; pc_next = nx; bus.instr_ready = rdy;
    bus.imem_valid = v; bus.imem_rdata = d;
    @(negedge clk);
    if (chk_en) cmp();
  endtask

  initial begin
    bus.imem_valid = 1'b0; bus.imem_rdata = '0; bus.instr_ready = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    chk_en = 1;
    step(1, 0, 0, 0, 0, 0);
    chk("rst_req", 16'(bus.imem_req), 16'h0);
    chk("rst_valid", 16'(bus.instr_valid), 16'h0);
    chk("rst_pc", pc_current, 16'h0000);
    chk("rst_fault", 16'(fetch_fault), 16'h0);

    // reset then run, answer on the second request cycle
    step(1, 0, 0, 0, 0, 0);
    chk("first_req", 16'(bus.imem_req), 16'h1);
    chk("first_addr", bus.imem_addr, 16'h0000);
    step(1, 0, 0, 0, 1, 16'hA123);
    step(1, 0, 0, 0, 0, 0);
    chk("first_instr", bus.instr, 16'hA123);
    chk("first_ivalid", 16'(bus.instr_valid), 16'h1);
    repeat (5) step(1, 0, 0, 0, 0, 0);
    chk("stall_instr", bus.instr, 16'hA123);
    chk("stall_ivalid", 16'(bus.instr_valid), 16'h1);
    step(1, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("accepted_ivalid", 16'(bus.instr_valid), 16'h0);
    chk("waitpc_req", 16'(bus.imem_req), 16'h0);
    step(1, 1, 16'h0005, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("load5_addr", bus.imem_addr, 16'h0005);

    // redirect while fetching 0x0006
    step(1, 0, 0, 0, 1, 16'h1111);
    step(1, 0, 0, 1, 0, 0);
    step(1, 1, 16'h0006, 0, 0, 0);
    step(1, 1, 16'h0040, 0, 0, 0);
    chk("fetch6_addr", bus.imem_addr, 16'h0006);
    step(1, 0, 0, 0, 0, 0);
    chk("drain_addr", bus.imem_addr, 16'h0006);
    chk("drain_pc", pc_current, 16'h0040);
    step(1, 0, 0, 0, 1, 16'hDEAD);
    step(1, 0, 0, 0, 0, 0);
    chk("post_drain_addr", bus.imem_addr, 16'h0040);
    chk("stale_dropped", 16'(bus.instr_valid), 16'h0);
    step(1, 0, 0, 0, 1, 16'hBEEF);
    step(1, 0, 0, 0, 0, 0);
    chk("redirect_instr", bus.instr, 16'hBEEF);

    // pc_load against ready in HOLD, then against a response in REQ
    step(1, 1, 16'h0080, 1, 0, 0);
    chk("hold_ivalid", 16'(bus.instr_valid), 16'h1);
    step(1, 1, 16'h0090, 0, 1, 16'h1234);
    chk("load_wins_ivalid", 16'(bus.instr_valid), 16'h0);
    chk("load_wins_addr", bus.imem_addr, 16'h0080);
    step(1, 0, 0, 0, 1, 16'h5678);
    chk("discard_ivalid", 16'(bus.instr_valid), 16'h0);
    chk("discard_addr", bus.imem_addr, 16'h0090);
    chk("discard_instr", bus.instr, 16'hBEEF);
    step(1, 0, 0, 1, 0, 0);
    chk("after_discard_instr", bus.instr, 16'h5678);

    // wrap address, then reset during DRAIN with a late response
    step(1, 1, 16'hFFFF, 0, 0, 0);
    step(1, 1, 16'h1234, 0, 0, 0);
    chk("wrap_addr", bus.imem_addr, 16'hFFFF);
    step(0, 0, 0, 0, 0, 0);
    chk("drain_wrap_addr", bus.imem_addr, 16'hFFFF);
    step(1, 0, 0, 0, 1, 16'hDEAD);
    chk("midrst_req", 16'(bus.imem_req), 16'h0);
    chk("midrst_pc", pc_current, 16'h0000);
    chk("midrst_instr", bus.instr, 16'h0000);
    step(1, 0, 0, 0, 0, 0);
    chk("late_rsp_ignored", 16'(bus.instr_valid), 16'h0);
    chk("restart_addr", bus.imem_addr, 16'h0000);

    // randomized traffic with a memory answering within three cycles
    auto_mem = 1; mbusy = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] nx;
      nx = ($urandom % 8 == 0) ? 16'hFFFF : 16'($urandom);
      step(($urandom % 300) != 0, ($urandom % 6) == 0, nx, 1'($urandom), 0, 0);
    end
    auto_mem = 0;

    // timeout with a silent memory
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    repeat (4) step(1, 0, 0, 0, 0, 0);
    chk("pre_timeout_req", 16'(bus.imem_req), 16'h1);
    chk("pre_timeout_fault", 16'(fetch_fault), 16'h0);
    step(1, 0, 0, 0, 0, 0);
    chk("timeout_fault", 16'(fetch_fault), 16'h1);
    chk("timeout_req", 16'(bus.imem_req), 16'h0);
    step(1, 1, 16'h0077, 1, 1, 16'h9999);
    step(1, 0, 0, 0, 0, 0);
    chk("fault_pc_frozen", pc_current, 16'h0000);
    chk("fault_sticky", 16'(fetch_fault), 16'h1);
    chk("fault_ivalid", 16'(bus.instr_valid), 16'h0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("fault_cleared", 16'(fetch_fault), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
